ahb_burst_decoder: RTL and testbench

//  Per-master AHB address decoder; burst-aware successor of the single-cycle decoder.

---
 rtl/ahb_burst_decoder.sv | 168 ++++++++++++++++
 tb/tb_ahb_burst_decoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ahb_burst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_decoder
// Purpose  : Burst-aware AHB address decoder for one master port. It locks the
//            slave select for a burst, re-decodes on NONSEQ and at 1KB
//            boundaries, and honours split and remap.
// Revision : 1.0  initial release
// ============================================================================
module ahb_burst_decoder #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int SLAVE_NUM      = 2,
    parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_LOW  = {32'h0000_2400, 32'h0000_2000},
    parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_HIGH = {32'h0000_27FF, 32'h0000_23FF},
    parameter int REMAP_SLV      = 1,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]                htrans,
    input  logic                      hready,
    input  logic                      hremap,
    input  logic [SLAVE_NUM-1:0]      hsplit,
    output logic [SLAVE_NUM-1:0]      hreq,
    output logic                      default_slv_sel,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [1:0] c_HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'd3;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEL   = 2'd1;
    localparam logic [1:0] c_ST_SPLIT = 2'd2;
    localparam logic [1:0] c_ST_ERR   = 2'd3;

    localparam logic [SLAVE_NUM-1:0]     c_ONE          = SLAVE_NUM'(1);
    localparam logic [SLAVE_NUM-1:0]     c_REMAP_ONEHOT = c_ONE << REMAP_SLV;
    localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_MAX      = '1;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [SLAVE_NUM-1:0]     r_sel_q;
    logic [SLAVE_NUM-1:0]     w_sel_nxt;
    logic [SLAVE_NUM-1:0]     r_hreq;
    logic [SLAVE_NUM-1:0]     w_hreq_nxt;
    logic                     r_default_slv_sel;
    logic                     w_default_nxt;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [ERR_CNT_WIDTH-1:0] w_err_cnt_nxt;
    logic                     w_err_entry;

    logic [SLAVE_NUM-1:0]     w_hit;
    logic [SLAVE_NUM-1:0]     w_hit_pri;
    logic [SLAVE_NUM-1:0]     w_dec_sel;
    logic                     w_dec_hit;
    logic                     w_dec_ev;
    logic                     w_nonseq_ev;
    logic                     w_idle_ev;
    logic                     w_split_hit;

    // Region compare per slave
    genvar g;
    generate
        for (g = 0; g < SLAVE_NUM; g++) begin : g_hit
            assign w_hit[g] = (haddr >= SLV_LOW[g*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH]) &&
                              (haddr <= SLV_HIGH[g*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH]);
        end
    endgenerate

    // Isolate the lowest set bit so the lowest index wins on overlap
    assign w_hit_pri = w_hit & (~w_hit + c_ONE);
    assign w_dec_hit = |w_hit;
    assign w_dec_sel = (hremap && w_hit_pri[0]) ? c_REMAP_ONEHOT : w_hit_pri;

    assign w_nonseq_ev = hready && (htrans == c_HTRANS_NONSEQ);
    assign w_idle_ev   = hready && (htrans == c_HTRANS_IDLE);
    assign w_dec_ev    = w_nonseq_ev ||
                         (hready && (htrans == c_HTRANS_SEQ) && (haddr[9:0] == 10'd0));
    assign w_split_hit = |(hsplit & r_sel_q);

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state           <= c_ST_IDLE;
            r_sel_q           <= '0;
            r_hreq            <= '0;
            r_default_slv_sel <= 1'b0;
            r_err_cnt         <= '0;
        end else begin
            r_state           <= w_state_nxt;
            r_sel_q           <= w_sel_nxt;
            r_hreq            <= w_hreq_nxt;
            r_default_slv_sel <= w_default_nxt;
            r_err_cnt         <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_q;
        w_err_entry = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_dec_ev) begin
                    if (w_dec_hit) begin
                        w_state_nxt = c_ST_SEL;
                        w_sel_nxt   = w_dec_sel;
                    end else begin
                        w_state_nxt = c_ST_ERR;
                        w_err_entry = 1'b1;
                    end
                end
            end
            c_ST_SEL: begin
                // Split beats any concurrent address; the master reissues it later
                if (w_split_hit) begin
                    w_state_nxt = c_ST_SPLIT;
                end else if (w_dec_ev) begin
                    if (w_dec_hit) begin
                        w_sel_nxt = w_dec_sel;
                    end else begin
                        w_state_nxt = c_ST_ERR;
                        w_err_entry = 1'b1;
                    end
                end else if (w_idle_ev) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_SPLIT: begin
                if (!w_split_hit) begin
                    w_state_nxt = c_ST_SEL;
                end
            end
            c_ST_ERR: begin
                // Only a fresh NONSEQ leaves the error slave; SEQ stays even at 1KB
                if (w_nonseq_ev) begin
                    if (w_dec_hit) begin
                        w_state_nxt = c_ST_SEL;
                        w_sel_nxt   = w_dec_sel;
                    end else begin
                        w_err_entry = 1'b1;
                    end
                end else if (w_idle_ev) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_hreq_nxt    = (w_state_nxt == c_ST_SEL) ? w_sel_nxt : '0;
        w_default_nxt = (w_state_nxt == c_ST_ERR);
        w_err_cnt_nxt = r_err_cnt;
        if (w_err_entry && (r_err_cnt != c_ERR_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
    end

    assign hreq            = r_hreq;
    assign default_slv_sel = r_default_slv_sel;
    assign err_cnt         = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_burst_decoder
// Purpose  : Directed self-checking bench for ahb_burst_decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_burst_decoder;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_NONSEQ = 2'd2;
    localparam logic [1:0] c_SEQ    = 2'd3;

    logic        hclk;
    logic        hreset_n;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hremap;
    logic [1:0]  hsplit;
    logic [1:0]  hreq;
    logic        default_slv_sel;
    logic [7:0]  err_cnt;

    int n_total = 0;
    int n_fail  = 0;

    ahb_burst_decoder #(
        .AHB_ADDR_WIDTH (32),
        .SLAVE_NUM      (2),
        .SLV_LOW        ({32'h0000_2400, 32'h0000_2000}),
        .SLV_HIGH       ({32'h0000_27FF, 32'h0000_23FF}),
        .REMAP_SLV      (1),
        .ERR_CNT_WIDTH  (8)
    ) u_dut (
        .hclk            (hclk),
        .hreset_n        (hreset_n),
        .haddr           (haddr),
        .htrans          (htrans),
        .hready          (hready),
        .hremap          (hremap),
        .hsplit          (hsplit),
        .hreq            (hreq),
        .default_slv_sel (default_slv_sel),
        .err_cnt         (err_cnt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one address phase, then sample 1ns after the clock edge that takes it
    task automatic phase(input logic [1:0] tr, input logic [31:0] a);
        htrans = tr;
        haddr  = a;
        @(posedge hclk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_hreq,
                             input logic e_dflt, input logic [7:0] e_cnt);
        check({tag, ".hreq"}, {30'd0, hreq}, {30'd0, e_hreq});
        check({tag, ".dflt"}, {31'd0, default_slv_sel}, {31'd0, e_dflt});
        check({tag, ".cnt"},  {24'd0, err_cnt}, {24'd0, e_cnt});
    endtask

    initial begin
        hreset_n = 1'b0;
        haddr    = '0;
        htrans   = c_IDLE;
        hready   = 1'b1;
        hremap   = 1'b0;
        hsplit   = 2'b00;
        repeat (2) @(posedge hclk);
        #1;
        check_out("reset", 2'b00, 1'b0, 8'd0);
        hreset_n = 1'b1;

        // 1: single NONSEQ then IDLE
        phase(c_NONSEQ, 32'h2000);  check_out("t1_sel",  2'b01, 1'b0, 8'd0);
        phase(c_IDLE,   32'h0);     check_out("t1_idle", 2'b00, 1'b0, 8'd0);

        // 2: burst lock then 1KB boundary re-decode
        phase(c_NONSEQ, 32'h23F8);  check_out("t2_ns",   2'b01, 1'b0, 8'd0);
        phase(c_SEQ,    32'h23FC);  check_out("t2_seq",  2'b01, 1'b0, 8'd0);
        phase(c_SEQ,    32'h2400);  check_out("t2_1kb",  2'b10, 1'b0, 8'd0);
        phase(c_IDLE,   32'h0);     check_out("t2_idle", 2'b00, 1'b0, 8'd0);

        // 3: decode miss, SEQ at boundary stays in ERR, recovery on NONSEQ
        phase(c_NONSEQ, 32'h5000);  check_out("t3_miss", 2'b00, 1'b1, 8'd1);
        phase(c_NONSEQ, 32'h2404);  check_out("t3_rec",  2'b10, 1'b0, 8'd1);
        phase(c_NONSEQ, 32'h5000);  check_out("t3_miss2", 2'b00, 1'b1, 8'd2);
        phase(c_SEQ,    32'h2800);  check_out("t3_seqkb", 2'b00, 1'b1, 8'd2);
        phase(c_NONSEQ, 32'h2404);  check_out("t3_rec2", 2'b10, 1'b0, 8'd2);
        phase(c_IDLE,   32'h0);     check_out("t3_idle", 2'b00, 1'b0, 8'd2);

        // 4: split drops concurrent NONSEQ; hready low holds SEL
        phase(c_NONSEQ, 32'h2000);  check_out("t4_sel",  2'b01, 1'b0, 8'd2);
        hready = 1'b0;
        phase(c_IDLE,   32'h0);     check_out("t4_wait", 2'b01, 1'b0, 8'd2);
        hready = 1'b1;
        hsplit = 2'b01;
        phase(c_NONSEQ, 32'h2400);  check_out("t4_split", 2'b00, 1'b0, 8'd2);
        hsplit = 2'b00;
        phase(c_NONSEQ, 32'h2400);  check_out("t4_resume", 2'b01, 1'b0, 8'd2);
        phase(c_IDLE,   32'h0);     check_out("t4_idle", 2'b00, 1'b0, 8'd2);

        // 5: remap at decode, hremap toggle mid-burst ignored
        hremap = 1'b1;
        phase(c_NONSEQ, 32'h2000);  check_out("t5_remap", 2'b10, 1'b0, 8'd2);
        hremap = 1'b0;
        phase(c_SEQ,    32'h2004);  check_out("t5_lock", 2'b10, 1'b0, 8'd2);
        phase(c_IDLE,   32'h0);     check_out("t5_idle", 2'b00, 1'b0, 8'd2);

        // 6a: asynchronous reset mid-burst, checked before the next edge
        phase(c_NONSEQ, 32'h2000);
        phase(c_SEQ,    32'h2004);  check_out("t6_pre",  2'b01, 1'b0, 8'd2);
        #2 hreset_n = 1'b0;
        #1 check_out("t6_arst", 2'b00, 1'b0, 8'd0);
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        phase(c_NONSEQ, 32'h5000);  check_out("t6_err",  2'b00, 1'b1, 8'd1);
        #2 hreset_n = 1'b0;
        #1 check_out("t6_arst_err", 2'b00, 1'b0, 8'd0);
        @(posedge hclk); #1;
        hreset_n = 1'b1;

        // 6b: error counter saturation
        for (int i = 0; i < 254; i++) begin
            phase(c_NONSEQ, 32'h5000);
            phase(c_IDLE,   32'h0);
        end
        check("t6_cnt254", {24'd0, err_cnt}, 32'h0000_00FE);
        phase(c_NONSEQ, 32'h5000);
        check("t6_cnt255", {24'd0, err_cnt}, 32'h0000_00FF);
        phase(c_IDLE,   32'h0);
        for (int i = 0; i < 20; i++) begin
            phase(c_NONSEQ, 32'h5000);
            phase(c_IDLE,   32'h0);
        end
        check("t6_sat", {24'd0, err_cnt}, 32'h0000_00FF);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
`default_nettype wire
